// File: rtl/bch_syndrome.sv
// bch_syndrome: bit-serial BCH syndrome generator over GF(2^C_M).
// Accepts one received bit per cycle (highest degree first) and accumulates
// S_1..S_2t by Horner's rule, S_j <= S_j*alpha^j ^ r. When C_N bits have been
// accepted, all 2t syndromes are presented in parallel with a one-cycle strobe.
//
// Ports:
//   I_clk      clock, rising edge
//   I_rst_n    asynchronous active-low reset
//   I_Bit      received codeword bit
//   I_Bit_v    I_Bit valid; a bit is accepted when I_Bit_v & O_Ready
//   I_Sop      accepted bit is the first bit (r_{n-1}) of a codeword
//   O_Ready    block accepts bits
//   O_Syn      packed syndromes, S_j at [j*C_M-1:(j-1)*C_M] (S_1 in LSBs)
//   O_Syn_v    one-cycle strobe, O_Syn complete
//   O_Err_free (only with BCH_SYN_ZERO_FLAG_EN) all syndromes zero
//
// Optional feature macro: BCH_SYN_ZERO_FLAG_EN
module bch_syndrome #(
  parameter int unsigned     C_M         = 5,
  parameter int unsigned     C_N         = 31,
  parameter int unsigned     C_T         = 3,
  parameter logic [C_M-1:0]  C_POLY_PRIM = 5'h05
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic                   I_Bit,
  input  logic                   I_Bit_v,
  input  logic                   I_Sop,
  output logic                   O_Ready,
  output logic [2*C_T*C_M-1:0]   O_Syn,
  output logic                   O_Syn_v
`ifdef BCH_SYN_ZERO_FLAG_EN
  ,
  output logic                   O_Err_free
`endif
);

  localparam int unsigned C_NSYN = 2 * C_T;
  localparam int unsigned C_CW   = $clog2(C_N + 1);
  localparam logic [C_CW-1:0] C_N_LAST = C_CW'(C_N);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [C_CW-1:0]               cnt_q, cnt_d;
  logic [C_NSYN-1:0][C_M-1:0]    syn_q, syn_d;
  logic [C_NSYN-1:0][C_M-1:0]    syn_init, syn_upd;
  logic [C_M-1:0]                mul_tmp;
  logic                          accept;
  logic                          load_out;

  // One multiply-by-alpha step: shift left, reduce by the primitive polynomial.
  function automatic logic [C_M-1:0] mul_alpha(input logic [C_M-1:0] x);
    mul_alpha = {x[C_M-2:0], 1'b0} ^ (x[C_M-1] ? C_POLY_PRIM : '0);
  endfunction

  // Index j holds S_{j+1}, so it needs j+1 chained alpha steps.
  always_comb begin
    mul_tmp  = '0;
    syn_upd  = '0;
    syn_init = '0;
    for (int unsigned j = 0; j < C_NSYN; j++) begin
      mul_tmp = syn_q[j];
      for (int unsigned k = 0; k <= j; k++) begin
        mul_tmp = mul_alpha(mul_tmp);
      end
      syn_upd[j]  = mul_tmp ^ C_M'(I_Bit);
      syn_init[j] = C_M'(I_Bit);
    end
  end

  assign O_Ready = I_rst_n & (state_q != ST_DONE);
  assign accept  = I_Bit_v & O_Ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    syn_d    = syn_q;
    load_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && I_Sop) begin
          syn_d   = syn_init;
          cnt_d   = C_CW'(1);
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          if (I_Sop) begin
            syn_d = syn_init;
            cnt_d = C_CW'(1);
          end else begin
            syn_d = syn_upd;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_ACC && cnt_d == C_N_LAST) begin
      state_d  = ST_DONE;
      load_out = 1'b1;
    end
  end

  // Output registers load on the edge entering DONE, so O_Syn is already
  // valid in the DONE cycle while O_Syn_v is high.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      syn_q   <= '0;
      O_Syn   <= '0;
      O_Syn_v <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      syn_q   <= syn_d;
      O_Syn_v <= load_out;
      if (load_out) begin
        O_Syn <= syn_d;
      end
    end
  end

`ifdef BCH_SYN_ZERO_FLAG_EN
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_Err_free <= 1'b0;
    end else if (load_out) begin
      O_Err_free <= (syn_d == '0);
    end
  end
`endif

endmodule

// File: doc/bch_syndrome.md
Name: bch_syndrome

Overview:
- Bit-serial BCH syndrome generator over GF(2^C_M).
- Consumes one received codeword bit per accepted cycle, highest-degree bit first.
- Computes syndromes S_1..S_2t by Horner accumulation: each S_j <= S_j*alpha^j XOR r.
- Sits upstream of the key-equation / error-locator stage, which uses the bit-serial GF multiplier. Presents all 2t syndromes in parallel with a one-cycle valid strobe.

Parameters:
- C_M, 5, field symbol width m; field is GF(2^m).
- C_N, 31, codeword length in bits; must be <= 2^m - 1.
- C_T, 3, correctable errors t; syndrome count is 2t.
- C_POLY_PRIM, 5'h05, primitive polynomial low m coefficients; the x^m term is implied (default is x^5+x^2+1).

Ports:
- I_clk  input  1  clock; all logic on the rising edge.
- I_rst_n  input  1  asynchronous active-low reset.
- I_Bit  input  1  received codeword bit.
- I_Bit_v  input  1  I_Bit valid; a bit is accepted when I_Bit_v & O_Ready.
- I_Sop  input  1  qualifies the accepted bit as the first bit (r_{n-1}) of a codeword.
- O_Ready  output  1  block accepts bits.
- O_Syn  output  2*C_T*C_M  packed syndromes; S_j at bits [j*C_M-1 : (j-1)*C_M], so S_1 is in the LSBs.
- O_Syn_v  output  1  one-cycle strobe; O_Syn is complete.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, bit counter 0, all syndrome registers 0, O_Syn 0, O_Syn_v 0, O_Ready 0 while I_rst_n low.
- FSM states:
  - IDLE: O_Ready=1. An accepted bit with I_Sop=1 sets S_j <= {m-1 zeros, I_Bit} for all j, sets count=1, and moves to ACC. An accepted bit with I_Sop=0 is dropped.
  - ACC: O_Ready=1. Each accepted bit updates S_j <= mulconst(S_j, alpha^j) XOR {0, I_Bit} for all j, and count increments. Cycles with I_Bit_v=0 leave all state unchanged; gaps of any length are allowed.
  - Frame completion: when the accepted bit makes count==C_N, go to DONE.
  - Restart in ACC: an accepted bit with I_Sop=1 restarts the frame, identical to the IDLE first-bit action (count=1, syndromes reinitialised). The partial frame is discarded and no O_Syn_v is issued for it.
  - DONE: O_Ready=0; bits presented are not accepted. O_Syn <= syndrome registers and O_Syn_v=1 for exactly this cycle. Next state is IDLE.
- Latency: O_Syn_v rises one cycle after the clock edge that accepts the C_N-th bit.
- O_Syn holds its value until the next DONE. O_Syn_v=0 in all other cycles.
- Constant multiply: mulconst(x, alpha^j) is combinational, built as j chained multiply-by-alpha steps. One step is: shift left 1; if bit m-1 was set, XOR C_POLY_PRIM. No multipliers are instantiated.
- Counter width: clog2(C_N+1). It never wraps, because a frame ends at C_N.
- Asserting I_rst_n low mid-frame discards the frame immediately; no O_Syn_v follows.

Optional Feature:
- Macro BCH_SYN_ZERO_FLAG_EN.
- Defined: adds output port O_Err_free (1 bit).
  - Registered in DONE alongside O_Syn: 1 when all 2t syndromes are zero, 0 otherwise.
  - Holds its value until the next DONE; reset value 0.
  - Downstream uses it to bypass error correction.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- All-zero codeword: 31 bits of 0, Sop on the first -> O_Syn_v pulse one cycle after the 31st bit; O_Syn = 0; O_Err_free=1 when enabled.
- Single error at degree 0: 30 zeros then a 1 as the last bit -> S_1..S_6 all 5'h01.
- Single error at degree 1: only bit 30 (second to last) set -> S_1..S_6 = 5'h02, 5'h04, 5'h08, 5'h10, 5'h05, 5'h0A.
- All-ones codeword (valid codeword) with random I_Bit_v gaps -> O_Syn = 0, exactly one O_Syn_v, pulse timing unaffected by gap placement.
- Restart and stray input:
  - Sop asserted again after 10 bits, then a 31-bit degree-1 error frame -> single O_Syn_v with the degree-1 values.
  - Non-Sop bits presented in IDLE -> no state change.
- I_rst_n pulsed low at bit 20 -> outputs 0 immediately, no O_Syn_v. The following full frame decodes correctly.
